// File: rtl/phase_count_readout.sv
// Purpose: multi-phase VCO readout; syncs taps, counts per-tap transitions, accumulates per decimation window.
// Latency: a tap toggle is counted SYNC_STAGES edges after it is sampled; sample_o updates on the edge after the last window cycle.
// Backpressure: one-deep valid/ready output register; a result arriving while valid_o&&!ready_i is dropped and overrun_o set.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           readout enable; dropping it aborts the current window
//   decim_i      window length minus one, latched at each window start
//   data_i       raw asynchronous VCO phase taps
//   sample_o     saturated transition count of the last window, with valid_o/ready_i
//   sat_o        sample_o was clipped at 2^ACC_WIDTH-1
//   overrun_o    sticky: a window result was dropped (cleared while en=0)
// Optional build macro PHASE_READOUT_RAW_EN adds raw_edges_o / raw_cnt_o,
// the registered per-cycle edge vector and its popcount.
module phase_count_readout #(
   parameter int PHASE_WIDTH = 11,
   parameter int SYNC_STAGES = 2,
   parameter int DECIM_WIDTH = 8,
   parameter int ACC_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [DECIM_WIDTH-1:0] decim_i,
   input  logic [PHASE_WIDTH-1:0] data_i,
   output logic [ACC_WIDTH-1:0]   sample_o,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic                   sat_o,
   output logic                   overrun_o
`ifdef PHASE_READOUT_RAW_EN
   ,
   output logic [PHASE_WIDTH-1:0]             raw_edges_o,
   output logic [$clog2(PHASE_WIDTH+1)-1:0]   raw_cnt_o
`endif
);

   localparam int CNT_W = $clog2(PHASE_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

   state_t                 state;
   logic [PHASE_WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [PHASE_WIDTH-1:0] prev_q;
   logic [PHASE_WIDTH-1:0] edge_vec;
   logic [CNT_W-1:0]       cnt;
   logic [ACC_WIDTH-1:0]   acc;
   logic                   win_sat;
   logic [DECIM_WIDTH-1:0] win_cnt;
   logic [DECIM_WIDTH-1:0] win_len;
   logic [ACC_WIDTH:0]     sum_full;
   logic [ACC_WIDTH-1:0]   acc_next;
   logic                   win_sat_next;
   logic                   res_fire;

   // Front end runs regardless of en so the pipeline is warm when a window starts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= data_i;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign edge_vec = sync_q[SYNC_STAGES-1] ^ prev_q;

   always_comb begin
      cnt = '0;
      for (int i = 0; i < PHASE_WIDTH; i++) cnt = cnt + CNT_W'(edge_vec[i]);
   end

   // One extra bit catches the carry; a carry means clip to all-ones.
   always_comb begin
      sum_full     = {1'b0, acc} + (ACC_WIDTH+1)'(cnt);
      acc_next     = sum_full[ACC_WIDTH] ? '1 : sum_full[ACC_WIDTH-1:0];
      win_sat_next = win_sat | sum_full[ACC_WIDTH];
      res_fire     = en && (state == RUN) && (win_cnt == win_len);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         win_sat   <= 1'b0;
         win_cnt   <= '0;
         win_len   <= '0;
         sample_o  <= '0;
         valid_o   <= 1'b0;
         sat_o     <= 1'b0;
         overrun_o <= 1'b0;
      end else begin
         // Output register: a result may replace a sample consumed in the same cycle.
         if (res_fire) begin
            if (!valid_o || ready_i) begin
               sample_o <= acc_next;
               sat_o    <= win_sat_next;
               valid_o  <= 1'b1;
            end else begin
               overrun_o <= 1'b1;
            end
         end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
         end

         if (!en) begin
            // Partial window discarded; a pending result stays until consumed.
            state     <= IDLE;
            overrun_o <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  state   <= PRIME;
                  acc     <= '0;
                  win_sat <= 1'b0;
                  win_cnt <= '0;
               end
               PRIME: begin
                  // Edges seen here may predate en and are not counted.
                  state   <= RUN;
                  win_len <= decim_i;
                  acc     <= '0;
                  win_sat <= 1'b0;
                  win_cnt <= '0;
               end
               RUN: begin
                  if (win_cnt == win_len) begin
                     acc     <= '0;
                     win_sat <= 1'b0;
                     win_cnt <= '0;
                     win_len <= decim_i;
                  end else begin
                     acc     <= acc_next;
                     win_sat <= win_sat_next;
                     win_cnt <= win_cnt + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef PHASE_READOUT_RAW_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         raw_edges_o <= '0;
         raw_cnt_o   <= '0;
      end else begin
         raw_edges_o <= edge_vec;
         raw_cnt_o   <= cnt;
      end
   end
`endif

endmodule
